// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - IEEE 754 single-precision field widths, bias and operand struct
// Shared by the float-to-int converter and the adder.
package float_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_MANT_W = FP_FRAC_W + 1;
  localparam int FP_BIAS   = 127;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = '1;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/round_rne.sv
// rtl/round_rne.sv - round-to-nearest-even increment on a magnitude with guard/round/sticky
// o_carry reports a carry out of the top bit so callers can detect a new leading one.
module round_rne #(
  parameter int W = 17
) (
  input  logic [W-1:0] i_mag,
  input  logic         i_g,
  input  logic         i_r,
  input  logic         i_s,
  output logic [W-1:0] o_mag,
  output logic         o_carry
);

  logic w_inc;

  assign w_inc = i_g & (i_r | i_s | i_mag[0]);
  assign {o_carry, o_mag} = {1'b0, i_mag} + {{W{1'b0}}, w_inc};

endmodule

// File: rtl/float_to_int_nb.sv
// rtl/float_to_int_nb.sv - 3-stage float32 to signed OUT_W-bit integer, round half to even
// FLOAT_TO_INT_SAT_EN: saturate out-of-range results by sign instead of returning the integer-indefinite value.
module float_to_int_nb
  import float_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             dout_ovf
);

  localparam int MAG_W = OUT_W + 1;
  localparam int FB    = 26;
  localparam int EXT_W = 64;

  localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] INT_MAX = ~INT_MIN;

  fp32_t w_in;
  assign w_in = din;

  // decode
  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [FP_EXP_W-1:0]  r_s1_exp;
  logic [FP_MANT_W-1:0] r_s1_mant;

  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else     r_s1_valid <= din_valid;
  end

  always_ff @(posedge clk) begin
    if (din_valid) begin
      r_s1_sign <= w_in.sign;
      r_s1_exp  <= w_in.exp;
      r_s1_mant <= (w_in.exp != '0) ? {1'b1, w_in.frac} : '0;
    end
  end

  // align: place the mantissa on a fixed point with FB fraction bits, so value = ext * 2^-FB
  logic             w_exp_ovf;
  logic             w_small;
  logic [5:0]       w_sh;
  logic [EXT_W-1:0] w_ext;
  logic             w_hi;
  logic [MAG_W-1:0] w_mag;
  logic             w_g;
  logic             w_r;
  logic             w_s;

  assign w_exp_ovf = (r_s1_exp == FP_EXP_MAX) | ({1'b0, r_s1_exp} >= 9'(FP_BIAS + OUT_W));
  assign w_small   = r_s1_exp < 8'(FP_BIAS - 1);
  assign w_sh      = (w_small | w_exp_ovf) ? 6'd0 : 6'(r_s1_exp - 8'(FP_BIAS - 3));
  assign w_ext     = {{(EXT_W-FP_MANT_W){1'b0}}, r_s1_mant} << w_sh;
  assign w_hi      = |w_ext[EXT_W-1:FB+MAG_W];

  always_comb begin
    w_mag = '0;
    w_g   = 1'b0;
    w_r   = 1'b0;
    w_s   = |r_s1_mant;
    if (!w_small) begin
      w_mag = w_ext[FB +: MAG_W];
      w_g   = w_ext[FB-1];
      w_r   = w_ext[FB-2];
      w_s   = |w_ext[FB-3:0];
    end
  end

  logic             r_s2_valid;
  logic             r_s2_sign;
  logic [MAG_W-1:0] r_s2_mag;
  logic             r_s2_g;
  logic             r_s2_r;
  logic             r_s2_s;
  logic             r_s2_pre_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_s2_valid <= 1'b0;
    else     r_s2_valid <= r_s1_valid;
  end

  always_ff @(posedge clk) begin
    if (r_s1_valid) begin
      r_s2_sign    <= r_s1_sign;
      r_s2_mag     <= w_mag;
      r_s2_g       <= w_g;
      r_s2_r       <= w_r;
      r_s2_s       <= w_s;
      r_s2_pre_ovf <= w_exp_ovf | w_hi;
    end
  end

  // round / pack
  logic [MAG_W-1:0] w_rmag;
  logic             w_carry;
  logic             w_big;
  logic             w_ovf;
  logic [OUT_W-1:0] w_int;
  logic [OUT_W-1:0] w_sat;

  round_rne #(.W(MAG_W)) u_round (
    .i_mag   (r_s2_mag),
    .i_g     (r_s2_g),
    .i_r     (r_s2_r),
    .i_s     (r_s2_s),
    .o_mag   (w_rmag),
    .o_carry (w_carry)
  );

  // 2^(OUT_W-1) itself is only representable when negative
  assign w_big = w_carry | w_rmag[OUT_W]
               | (w_rmag[OUT_W-1] & (~r_s2_sign | (|w_rmag[OUT_W-2:0])));
  assign w_ovf = r_s2_pre_ovf | w_big;
  assign w_int = r_s2_sign ? -w_rmag[OUT_W-1:0] : w_rmag[OUT_W-1:0];

`ifdef FLOAT_TO_INT_SAT_EN
  assign w_sat = r_s2_sign ? INT_MIN : INT_MAX;
`else
  assign w_sat = INT_MIN;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ovf   <= 1'b0;
    end else begin
      dout_valid <= r_s2_valid;
      if (r_s2_valid) begin
        dout     <= w_ovf ? w_sat : w_int;
        dout_ovf <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_float_to_int_nb.sv
// tb/tb_float_to_int_nb.sv - self-checking bench for float_to_int_nb (OUT_W=16)
// Expected results come from a real-arithmetic model fed through a 3-deep delay line.
module tb_float_to_int_nb;

  localparam int W = 16;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  logic         clk;
  logic         rst;
  logic [31:0]  din;
  logic         din_valid;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ovf;

  int n_chk;
  int n_fail;

  logic         m_v [1:3];
  logic [W-1:0] m_d [1:3];
  logic         m_o [1:3];
  logic [W-1:0] held_d;
  logic         held_o;

  float_to_int_nb #(.OUT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ovf   (dout_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_conv(input logic [31:0] f, output logic [W-1:0] d, output logic o);
    int     e;
    real    x;
    real    fl;
    longint r;
    logic   big;
    e   = int'(f[30:23]);
    big = 1'b0;
    r   = 0;
    if (e == 255 || e >= 127 + 40) begin
      big = 1'b1;
    end else if (e != 0) begin
      x  = real'({1'b1, f[22:0]}) * (2.0 ** (e - 150));
      fl = $floor(x);
      r  = longint'(fl);
      if ((x - fl > 0.5) || (x - fl == 0.5 && (r % 2) == 1)) r = r + 1;
      if (f[31]) r = -r;
    end
    o = big || (r > MAXV) || (r < MINV);
    if (o) begin
`ifdef FLOAT_TO_INT_SAT_EN
      d = f[31] ? W'(MINV) : W'(MAXV);
`else
      d = W'(MINV);
`endif
    end else begin
      d = r[W-1:0];
    end
  endfunction

  task automatic tick(input logic rv, input logic v, input logic [31:0] d);
    logic [W-1:0] ed;
    logic         eo;
    rst       = rv;
    din_valid = v;
    din       = d;
    ref_conv(d, ed, eo);
    @(posedge clk);
    #1;
    if (rv) begin
      for (int i = 1; i <= 3; i++) m_v[i] = 1'b0;
      held_d = '0;
      held_o = 1'b0;
    end else begin
      for (int i = 3; i >= 2; i--) begin
        m_v[i] = m_v[i-1];
        m_d[i] = m_d[i-1];
        m_o[i] = m_o[i-1];
      end
      m_v[1] = v;
      m_d[1] = ed;
      m_o[1] = eo;
      if (m_v[3]) begin
        held_d = m_d[3];
        held_o = m_o[3];
      end
    end
    n_chk++;
    assert (dout_valid === m_v[3]) else begin
      n_fail++;
      $error("FAIL valid: got %b expected %b at %0t", dout_valid, m_v[3], $time);
    end
    n_chk++;
    assert (dout === held_d) else begin
      n_fail++;
      $error("FAIL dout: got %h expected %h at %0t", dout, held_d, $time);
    end
    n_chk++;
    assert (dout_ovf === held_o) else begin
      n_fail++;
      $error("FAIL ovf: got %b expected %b at %0t", dout_ovf, held_o, $time);
    end
  endtask

  task automatic directed(input logic [31:0] f, input logic [W-1:0] ed, input logic eo);
    tick(1'b0, 1'b1, f);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    n_chk++;
    assert (dout_valid === 1'b1 && dout === ed && dout_ovf === eo) else begin
      n_fail++;
      $error("FAIL vec %h: got v=%b %h ovf=%b expected %h ovf=%b", f, dout_valid, dout, dout_ovf, ed, eo);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] f;
    f = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      f[30:23] = 8'($urandom_range(100, 127 + W + 2));
      if ($urandom_range(0, 2) == 0) f[10:0] = '0;
    end
    return f;
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    held_d    = '0;
    held_o    = 1'b0;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    for (int i = 1; i <= 3; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
      m_o[i] = 1'b0;
    end

    tick(1'b1, 1'b1, 32'h3FC00000);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);

    directed(32'h3FC00000, 16'h0002, 1'b0);
    directed(32'h40200000, 16'h0002, 1'b0);
    directed(32'hC0200000, 16'hFFFE, 1'b0);
    directed(32'h3F000000, 16'h0000, 1'b0);
    directed(32'h3F400000, 16'h0001, 1'b0);
    directed(32'h46FFFE00, 16'h7FFF, 1'b0);
    directed(32'hC7000000, 16'h8000, 1'b0);
    directed(32'h00000001, 16'h0000, 1'b0);
    directed(32'h80000000, 16'h0000, 1'b0);
    directed(32'h00000000, 16'h0000, 1'b0);
    directed(32'hFF800000, 16'h8000, 1'b1);
`ifdef FLOAT_TO_INT_SAT_EN
    directed(32'h46FFFF00, 16'h7FFF, 1'b1);
    directed(32'h7F800000, 16'h7FFF, 1'b1);
`else
    directed(32'h46FFFF00, 16'h8000, 1'b1);
    directed(32'h7F800000, 16'h8000, 1'b1);
    directed(32'h47000000, 16'h8000, 1'b1);
    directed(32'hC7800000, 16'h8000, 1'b1);
`endif

    for (int sent = 0; sent < 100; ) begin
      if ($urandom_range(0, 2) != 0) begin
        tick(1'b0, 1'b1, rand_op());
        sent++;
      end else begin
        tick(1'b0, 1'b0, $urandom);
      end
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);

    tick(1'b0, 1'b1, 32'h40200000);
    tick(1'b0, 1'b1, 32'hC0200000);
    tick(1'b0, 1'b1, 32'h46FFFE00);
    tick(1'b1, 1'b1, 32'h3F400000);
    n_chk++;
    assert (dout === '0 && dout_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL rst_flush: got v=%b %h expected v=0 0000", dout_valid, dout);
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'($urandom_range(0, 1)), rand_op());
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
